// File: rtl/audio_pkg.sv
// Shared definitions for the I2S line-in receive path: channel encoding, default sample width, rx FSM states.
// Latency: none (types and constants only).
// Backpressure: none.
//
// Contents:
//   I2S_LEFT / I2S_RIGHT  word-clock level that selects each channel
//   AUDIO_WIDTH           default captured bits per channel
//   rx_state_e            receiver FSM state encoding
package audio_pkg;

    localparam logic I2S_LEFT    = 1'b0;
    localparam logic I2S_RIGHT   = 1'b1;
    localparam int   AUDIO_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one raw I2S pin, with optional rising-edge detect on the synced level.
// Latency: SYNC_STAGES clk from pin to dout; rise is valid in the same cycle dout first reads 1.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   din         raw asynchronous input
//   dout        synchronized level
//   rise        1-cycle pulse when dout goes 0 -> 1 (held 0 when RISE_DET is 0)
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RISE_DET    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        // Edge history is only kept where someone wants the edge.
        prev_d = RISE_DET ? sync_q[SYNC_STAGES-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = RISE_DET & dout & ~prev_q;

endmodule

// File: rtl/i2s_line_in_receiver.sv
// I2S receiver: oversamples bclk/lrclk/sdata from the codec ADC and emits paired left/right samples.
// Latency: sample_valid rises SYNC_STAGES+2 clk after the raw bclk rise carrying the right-channel LSB.
// Backpressure: none; the codec cannot be stalled, consumers must take each sample_valid pulse.
//
// Ports:
//   clk, reset            system clock (clk_100), synchronous active-high reset
//   bclk, lrclk, sdata    raw asynchronous I2S pins from the codec (lrclk 0 = left)
//   sample_l, sample_r    last complete L/R pair, two's complement
//   sample_valid          1-cycle pulse, sample_l/r updated this cycle
//   frame_err             1-cycle pulse on a short or overlong half-frame
//   locked                high after the first good L+R pair, cleared by frame_err
module i2s_line_in_receiver
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_WIDTH,
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] sample_l,
    output logic [DATA_WIDTH-1:0] sample_r,
    output logic                  sample_valid,
    output logic                  frame_err,
    output logic                  locked
);

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int SLOT_W = $clog2(SLOT_BITS + 2);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOT_BITS);

    // ---------------------------------------------------------------
    // Input synchronizers
    // ---------------------------------------------------------------
    logic bclk_lvl_unused;
    logic bclk_rise;
    logic lrclk_s;
    logic lrclk_rise_unused;
    logic sdata_s;
    logic sdata_rise_unused;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RISE_DET(1'b1)) u_sync_bclk (
        .clk   (clk),
        .reset (reset),
        .din   (bclk),
        .dout  (bclk_lvl_unused),
        .rise  (bclk_rise)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sync_lrclk (
        .clk   (clk),
        .reset (reset),
        .din   (lrclk),
        .dout  (lrclk_s),
        .rise  (lrclk_rise_unused)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sync_sdata (
        .clk   (clk),
        .reset (reset),
        .din   (sdata),
        .dout  (sdata_s),
        .rise  (sdata_rise_unused)
    );

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    rx_state_e             state_q, state_d;
    logic                  lr_prev_q, lr_prev_d;
    logic                  lr_seen_q, lr_seen_d;
    logic                  chan_q, chan_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  commit_q, commit_d;
    logic                  commit_chan_q, commit_chan_d;
    logic [DATA_WIDTH-1:0] held_l_q, held_l_d;
    logic                  have_l_q, have_l_d;
    logic [DATA_WIDTH-1:0] sample_l_q, sample_l_d;
    logic [DATA_WIDTH-1:0] sample_r_q, sample_r_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  locked_q, locked_d;

    // lr_prev is meaningless until it has been loaded by one bclk rise after
    // reset; without this qualifier a stream that starts in a right slot
    // would look like a word-clock edge against the cleared lr_prev.
    logic lr_edge;
    logic last_bit;
    logic slot_overrun;
    logic short_slot;
    logic pad_err;
    logic word_done;

    always_comb begin
        lr_edge      = bclk_rise & lr_seen_q & (lrclk_s != lr_prev_q);
        last_bit     = (bit_cnt_q == LAST_BIT);
        slot_overrun = bclk_rise & ~lr_edge & (slot_cnt_q >= SLOT_MAX);
        short_slot   = (state_q == SHIFT) & lr_edge & ~last_bit;
        pad_err      = (state_q == PAD) & slot_overrun;
        word_done    = (state_q == SHIFT) & bclk_rise & last_bit;
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // The bclk rise that reveals a word-clock edge is itself the one-bit
    // delay slot (it carries the previous slot's last bit), so DELAY only
    // needs one clk to clear the bit counter before the MSB rise arrives.
    // The clk >= 4x bclk ratio guarantees no rise lands in DELAY.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lr_edge) state_d = DELAY;
            end
            DELAY: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (lr_edge) begin
                    state_d = DELAY;
                end else if (word_done) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (lr_edge) begin
                    state_d = DELAY;
                end else if (slot_overrun) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM outputs and datapath next values
    // ---------------------------------------------------------------
    always_comb begin
        lr_prev_d      = lr_prev_q;
        lr_seen_d      = lr_seen_q;
        chan_d         = chan_q;
        bit_cnt_d      = bit_cnt_q;
        slot_cnt_d     = slot_cnt_q;
        shreg_d        = shreg_q;
        commit_d       = 1'b0;
        commit_chan_d  = commit_chan_q;
        held_l_d       = held_l_q;
        have_l_d       = have_l_q;
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        locked_d       = locked_q;

        if (bclk_rise) begin
            lr_prev_d = lrclk_s;
            lr_seen_d = 1'b1;
            if (lr_edge) begin
                slot_cnt_d = '0;
            end else if (state_q != IDLE) begin
                slot_cnt_d = slot_cnt_q + SLOT_W'(1);
            end
        end

        // Channel of the slot now starting; the word that may complete on
        // this same rise still belongs to the old chan_q.
        if (lr_edge) chan_d = lrclk_s;

        if (state_q == DELAY) bit_cnt_d = '0;

        if ((state_q == SHIFT) && bclk_rise && !short_slot) begin
            shreg_d   = {shreg_q[DATA_WIDTH-2:0], sdata_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        // The word is fully in shreg one cycle after word_done; pairing is
        // done in that cycle so the outputs and the valid pulse line up.
        if (word_done) begin
            commit_d      = 1'b1;
            commit_chan_d = chan_q;
        end

        if (commit_q) begin
            if (commit_chan_q == I2S_LEFT) begin
                held_l_d = shreg_q;
                have_l_d = 1'b1;
            end else if ((commit_chan_q == I2S_RIGHT) && have_l_q) begin
                sample_l_d     = held_l_q;
                sample_r_d     = shreg_q;
                sample_valid_d = 1'b1;
                have_l_d       = 1'b0;
                locked_d       = 1'b1;
            end
        end

        // Errors only occur on a rise, never in a commit cycle.
        if (short_slot || pad_err) begin
            frame_err_d = 1'b1;
            have_l_d    = 1'b0;
            locked_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lr_prev_q      <= 1'b0;
            lr_seen_q      <= 1'b0;
            chan_q         <= I2S_LEFT;
            bit_cnt_q      <= '0;
            slot_cnt_q     <= '0;
            shreg_q        <= '0;
            commit_q       <= 1'b0;
            commit_chan_q  <= I2S_LEFT;
            held_l_q       <= '0;
            have_l_q       <= 1'b0;
            sample_l_q     <= '0;
            sample_r_q     <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            lr_prev_q      <= lr_prev_d;
            lr_seen_q      <= lr_seen_d;
            chan_q         <= chan_d;
            bit_cnt_q      <= bit_cnt_d;
            slot_cnt_q     <= slot_cnt_d;
            shreg_q        <= shreg_d;
            commit_q       <= commit_d;
            commit_chan_q  <= commit_chan_d;
            held_l_q       <= held_l_d;
            have_l_q       <= have_l_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
            locked_q       <= locked_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_line_in_receiver.sv
// Bench for i2s_line_in_receiver: standard-I2S BFM (bclk = clk/32, 32-bit slots) with an L/R scoreboard.
// Latency: checks SYNC_STAGES+2 clk from the raw right-LSB bclk rise to sample_valid.
// Backpressure: none; the BFM free-runs like the codec.
module tb_i2s_line_in_receiver;
    import audio_pkg::*;

    localparam int DW   = 24;
    localparam int SYNC = 2;
    localparam int HALF = 16;
    localparam int SLOT = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic [DW-1:0] sample_l;
    logic [DW-1:0] sample_r;
    logic          sample_valid;
    logic          frame_err;
    logic          locked;

    int cnt_total = 0;
    int cnt_bad   = 0;
    int err_cnt   = 0;
    int valid_cnt = 0;
    int cyc       = 0;
    int lsb_cyc   = 0;
    int err_base;

    logic [DW-1:0] exp_l[$];
    logic [DW-1:0] exp_r[$];

    i2s_line_in_receiver #(
        .DATA_WIDTH  (DW),
        .SLOT_BITS   (SLOT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        cnt_total++;
        if (got !== want) begin
            cnt_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string where);
        chk({where, "_sample_l"}, 32'(sample_l), 32'h0);
        chk({where, "_sample_r"}, 32'(sample_r), 32'h0);
        chk({where, "_valid"},    32'(sample_valid), 32'h0);
        chk({where, "_err"},      32'(frame_err), 32'h0);
        chk({where, "_locked"},   32'(locked), 32'h0);
    endtask

    // One bclk period: lrclk/sdata change with bclk falling, the codec's data
    // is sampled by the receiver on the rising half. Optionally pulses reset
    // for one clk in the middle of the high half.
    task automatic drive_bit(input logic lr, input logic d, input logic mark_lsb, input logic rst_here);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        repeat (HALF) @(negedge clk);
        bclk = 1'b1;
        if (mark_lsb) lsb_cyc = cyc;
        if (rst_here) begin
            repeat (4) @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk_zero_outputs("rst_midword");
            @(negedge clk);
            reset = 1'b0;
            repeat (HALF - 5) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    // Slot position 0 carries the previous slot's last bit (padding 0),
    // positions 1..DW carry the word MSB first, the rest is padding.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int first, input int len, input int rst_at);
        for (int k = first; k < len; k++) begin
            drive_bit(lr, (k >= 1 && k <= DW) ? w[DW-k] : 1'b0, (lr == I2S_RIGHT) && (k == DW), k == rst_at);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic expect_pair);
        if (expect_pair) begin
            exp_l.push_back(l);
            exp_r.push_back(r);
        end
        send_slot(I2S_LEFT, l, 0, SLOT, -1);
        send_slot(I2S_RIGHT, r, 0, SLOT, -1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on every sample_valid.
    initial begin
        logic [DW-1:0] el;
        logic [DW-1:0] er;
        forever begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                err_cnt++;
                chk("err_valid_exclusive", 32'(sample_valid), 32'h0);
            end
            if (sample_valid) begin
                valid_cnt++;
                chk("valid_expected", 32'(exp_l.size() > 0), 32'h1);
                if (exp_l.size() > 0) begin
                    el = exp_l.pop_front();
                    er = exp_r.pop_front();
                    chk("sample_l", 32'(sample_l), 32'(el));
                    chk("sample_r", 32'(sample_r), 32'(er));
                    chk("locked_on_valid", 32'(locked), 32'h1);
                    chk("latency", 32'(cyc - lsb_cyc), 32'(SYNC + 2));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        cnt_bad++;
        $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bclk  = 1'b0;
        lrclk = I2S_RIGHT;
        sdata = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_zero_outputs("after_reset");
        @(negedge clk);

        // Lead-in right slot so the first left slot starts on a word-clock edge.
        send_slot(I2S_RIGHT, '0, 0, SLOT, -1);

        // 1: single frame
        send_frame(24'h123456, 24'hABCDEF, 1'b1);
        chk("t1_locked", 32'(locked), 32'h1);
        chk("t1_drained", 32'(exp_l.size()), 32'h0);

        // 2: extreme values, back to back
        send_frame(24'h800000, 24'h7FFFFF, 1'b1);
        send_frame(24'h000000, 24'hFFFFFF, 1'b1);
        send_frame(24'h000001, 24'h000002, 1'b1);
        chk("t2_drained", 32'(exp_l.size()), 32'h0);

        // 3: stream resumes mid right slot after reset
        do_reset(2);
        send_slot(I2S_RIGHT, 24'h777777, 10, SLOT, -1);
        chk("t3_not_locked", 32'(locked), 32'h0);
        send_frame(24'h2468AC, 24'h13579B, 1'b1);
        chk("t3_locked", 32'(locked), 32'h1);
        chk("t3_drained", 32'(exp_l.size()), 32'h0);

        // 4: left slot cut to 10 data bits, orphan right dropped
        err_base = err_cnt;
        send_slot(I2S_LEFT, 24'h55AA55, 0, 11, -1);
        send_slot(I2S_RIGHT, 24'h0F0F0F, 0, SLOT, -1);
        chk("t4_err_pulses", 32'(err_cnt - err_base), 32'h1);
        chk("t4_unlocked", 32'(locked), 32'h0);
        chk("t4_hold_l", 32'(sample_l), 32'h2468AC);
        chk("t4_hold_r", 32'(sample_r), 32'h13579B);
        send_frame(24'hC0FFEE, 24'h0BEEF0, 1'b1);
        chk("t4_relocked", 32'(locked), 32'h1);

        // 5: overlong slot (40 bclk)
        err_base = err_cnt;
        send_slot(I2S_LEFT, 24'h3C3C3C, 0, 40, -1);
        chk("t5_err_pulses", 32'(err_cnt - err_base), 32'h1);
        chk("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
        chk("t5_unlocked", 32'(locked), 32'h0);
        send_slot(I2S_RIGHT, 24'h111111, 0, SLOT, -1);
        send_frame(24'h0A0B0C, 24'hD0E0F0, 1'b1);
        chk("t5_relocked", 32'(locked), 32'h1);

        // 6: 1-clk reset at bit 12 of a left word
        send_slot(I2S_LEFT, 24'h5A5A5A, 0, SLOT, 12);
        send_slot(I2S_RIGHT, 24'h222222, 0, SLOT, -1);
        chk("t6_not_locked", 32'(locked), 32'h0);
        send_frame(24'h654321, 24'hFEDCBA, 1'b1);
        chk("t6_locked", 32'(locked), 32'h1);

        repeat (8) @(negedge clk);
        chk("final_drained", 32'(exp_l.size()), 32'h0);
        chk("final_valid_count", 32'(valid_cnt), 32'd8);
        chk("final_err_count", 32'(err_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
        $finish;
    end

endmodule
